// File: rtl/dev_irq_bridge_pkg.sv
// Shared constants for the CPU-to-peripheral bridge: address map, FSM encoding
// and the interrupt priority encoder.
package dev_irq_bridge_pkg;

  localparam logic [31:0] DEV_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] CTL_BASE_DEF = 32'h0000_7F80;

  localparam logic [3:0] OFS_MASK = 4'h0;
  localparam logic [3:0] OFS_PEND = 4'h4;
  localparam logic [3:0] OFS_ID   = 4'h8;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;

  localparam logic [2:0] INT_NONE = 3'd7;

  // Lowest-numbered set bit wins; INT_NONE when nothing is active.
  function automatic logic [2:0] prio_enc(input logic [5:0] v);
    prio_enc = INT_NONE;
    for (int i = 5; i >= 0; i--)
      if (v[i]) prio_enc = 3'(i);
  endfunction

endpackage

// File: rtl/dev_irq_bridge_irq_pend_ctrl.sv
// Interrupt pending latches, mask gating and priority encoding for the bridge.
// BRIDGE_LEVEL_IRQ_EN selects level-mirrored pending instead of sticky edge capture.
module irq_pend_ctrl
  import dev_irq_bridge_pkg::*;
#(
  parameter int NDEV = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NDEV-1:0] i_dev_irq,
  input  logic            i_int_ack,
  input  logic [NDEV-1:0] i_mask,
  input  logic [NDEV-1:0] i_pend_clr,
  output logic [NDEV-1:0] o_pend,
  output logic [5:0]      o_hwint,
  output logic [2:0]      o_int_id
);

  logic [NDEV-1:0] r_pend;
  logic [5:0]      w_hw;

  always_comb begin
    w_hw = '0;
    w_hw[NDEV-1:0] = r_pend & i_mask;
  end

  assign o_pend   = r_pend;
  assign o_hwint  = w_hw;
  assign o_int_id = prio_enc(w_hw);

`ifdef BRIDGE_LEVEL_IRQ_EN
  logic w_unused;
  assign w_unused = i_int_ack | (|i_pend_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= i_dev_irq;
  end
`else
  logic [NDEV-1:0] r_irq_q;
  logic [NDEV-1:0] w_ack_clr;

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NDEV; i++)
      if (o_int_id == 3'(i)) w_ack_clr[i] = i_int_ack;
  end

  // A fresh edge is applied after the clears so a same-cycle set survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_q <= '0;
      r_pend  <= '0;
    end else begin
      r_irq_q <= i_dev_irq;
      r_pend  <= (r_pend & ~(w_ack_clr | i_pend_clr)) | (i_dev_irq & ~r_irq_q);
    end
  end
`endif

endmodule

// File: rtl/dev_irq_bridge.sv
// CPU data-port bridge to NDEV register-window peripherals plus MASK/PENDING/ID
// control registers; build with BRIDGE_LEVEL_IRQ_EN for level-mirrored IRQs.
module dev_irq_bridge
  import dev_irq_bridge_pkg::*;
#(
  parameter int          NDEV     = 2,
  parameter logic [31:0] DEV_BASE = DEV_BASE_DEF,
  parameter logic [31:0] CTL_BASE = CTL_BASE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  output logic             bus_err,
  output logic [1:0]       dev_addr,
  output logic [31:0]      dev_wdata,
  output logic [NDEV-1:0]  dev_we,
  input  logic [32*NDEV-1:0] dev_rdata,
  input  logic [NDEV-1:0]  dev_irq,
  input  logic             int_ack,
  output logic [5:0]       hwint,
  output logic [2:0]       int_id
);

  logic [0:0]      r_state;
  logic [NDEV-1:0] r_mask;
  logic [31:0]     r_rdata;

  logic [NDEV-1:0] w_pend, w_dev_sel, w_pend_clr;
  logic [5:0]      w_hwint;
  logic [2:0]      w_int_id;
  logic [27:0]     w_win;
  logic [31:0]     w_dev_rd, w_ctl_rd, w_rd_sel;
  logic            w_aligned, w_dev_hit, w_ctl_hit, w_mapped;
  logic            w_idle_req, w_wr, w_rd, w_err, w_mask_we, w_pend_we;

  always_comb begin
    w_aligned = (cpu_addr[1:0] == 2'b00);
    w_win     = cpu_addr[31:4] - DEV_BASE[31:4];
    w_dev_sel = '0;
    w_dev_rd  = '0;
    for (int i = 0; i < NDEV; i++)
      if (w_aligned && w_win == 28'(i)) begin
        w_dev_sel[i] = 1'b1;
        w_dev_rd     = dev_rdata[32*i +: 32];
      end
    w_dev_hit = |w_dev_sel;
    w_ctl_hit = w_aligned && (cpu_addr[31:4] == CTL_BASE[31:4]) && (cpu_addr[3:2] != 2'b11);
    w_ctl_rd  = '0;
    case (cpu_addr[3:0])
      OFS_MASK: w_ctl_rd[NDEV-1:0] = r_mask;
      OFS_PEND: w_ctl_rd[NDEV-1:0] = w_pend;
      default:  w_ctl_rd[2:0]      = w_int_id;
    endcase
    w_mapped = w_dev_hit | w_ctl_hit;
    w_rd_sel = w_dev_hit ? w_dev_rd : w_ctl_rd;
  end

  // Gating with rst makes every handshake output drop the instant reset asserts.
  assign w_idle_req = rst && cpu_req && (r_state == ST_IDLE);
  assign w_wr       = w_idle_req &  cpu_we & w_mapped;
  assign w_rd       = w_idle_req & ~cpu_we & w_mapped;
  assign w_err      = w_idle_req & ~w_mapped;
  assign w_mask_we  = w_wr & w_ctl_hit & (cpu_addr[3:0] == OFS_MASK);
  assign w_pend_we  = w_wr & w_ctl_hit & (cpu_addr[3:0] == OFS_PEND);
  assign w_pend_clr = w_pend_we ? cpu_wdata[NDEV-1:0] : '0;

  assign cpu_ready = w_wr | w_err | (rst && (r_state == ST_RD_WAIT));
  assign bus_err   = w_err;
  assign dev_we    = w_wr ? w_dev_sel : '0;
  assign dev_addr  = rst ? cpu_addr[3:2] : 2'b00;
  assign dev_wdata = rst ? cpu_wdata : 32'h0;
  assign cpu_rdata = r_rdata;
  assign hwint     = w_hwint;
  assign int_id    = w_int_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd) begin
            r_rdata <= w_rd_sel;
            r_state <= ST_RD_WAIT;
          end else if (w_err) begin
            r_rdata <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_mask_we) r_mask <= cpu_wdata[NDEV-1:0];
    end
  end

  irq_pend_ctrl #(.NDEV(NDEV)) u_irq (
    .clk        (clk),
    .rst        (rst),
    .i_dev_irq  (dev_irq),
    .i_int_ack  (int_ack),
    .i_mask     (r_mask),
    .i_pend_clr (w_pend_clr),
    .o_pend     (w_pend),
    .o_hwint    (w_hwint),
    .o_int_id   (w_int_id)
  );

endmodule

// File: tb/tb_dev_irq_bridge.sv
// Scoreboard bench for dev_irq_bridge: accesses push expected responses, a
// negedge monitor pops them on cpu_ready and checks IRQ outputs against a model.
module tb_dev_irq_bridge;

  localparam int          NDEV     = 2;
  localparam logic [31:0] DEV_BASE = 32'h7F00;
  localparam logic [31:0] MASK_A   = 32'h7F80;
  localparam logic [31:0] PEND_A   = 32'h7F84;
  localparam logic [31:0] ID_A     = 32'h7F88;

  logic               clk = 1'b0, rst = 1'b0;
  logic               cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]        cpu_addr = '0, cpu_wdata = '0;
  logic [31:0]        cpu_rdata;
  logic               cpu_ready, bus_err;
  logic [1:0]         dev_addr;
  logic [31:0]        dev_wdata;
  logic [NDEV-1:0]    dev_we;
  logic [32*NDEV-1:0] dev_rdata = '0;
  logic [NDEV-1:0]    dev_irq = '0;
  logic               int_ack = 1'b0;
  logic [5:0]         hwint;
  logic [2:0]         int_id;

  dev_irq_bridge #(.NDEV(NDEV)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .bus_err(bus_err),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_rdata(dev_rdata),
    .dev_irq(dev_irq), .int_ack(int_ack), .hwint(hwint), .int_id(int_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              rd;
    bit              err;
    logic [31:0]     rdata;
    logic [NDEV-1:0] we;
    logic [1:0]      a;
    logic [31:0]     wd;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;
  bit   rand_irq = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: pending bits as a set, updated once per clock from the rules.
  logic [NDEV-1:0] m_mask, m_pend, m_irq_q;

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return 7;
  endfunction

  function automatic logic [5:0] m_hw();
    return 6'(m_pend & m_mask);
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [NDEV-1:0] clr;
    int id;
    if (!rst) begin
      m_mask = '0; m_pend = '0; m_irq_q = '0;
    end else begin
      clr = '0;
      id  = lowest(m_hw());
`ifdef BRIDGE_LEVEL_IRQ_EN
      m_pend = dev_irq;
`else
      if (int_ack && id != 7) clr[id] = 1'b1;
      if (cpu_req && cpu_we && cpu_addr == PEND_A) clr = clr | cpu_wdata[NDEV-1:0];
      m_pend = (m_pend & ~clr) | (dev_irq & ~m_irq_q);
`endif
      if (cpu_req && cpu_we && cpu_addr == MASK_A) m_mask = cpu_wdata[NDEV-1:0];
      m_irq_q = dev_irq;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      chk("hwint", 32'(hwint), 32'(m_hw()));
      chk("int_id", 32'(int_id), 32'(lowest(m_hw())));
      if (cpu_ready) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ready: got ready=1 expected no pending access at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("bus_err", 32'(bus_err), 32'(e.err));
          if (e.rd && !e.err) chk("rdata", cpu_rdata, e.rdata);
          if (!e.rd && !e.err) begin
            chk("dev_we", 32'(dev_we), 32'(e.we));
            chk("dev_addr", 32'(dev_addr), 32'(e.a));
            chk("dev_wdata", dev_wdata, e.wd);
          end else begin
            chk("dev_we_quiet", 32'(dev_we), 32'h0);
          end
        end
      end else begin
        chk("idle_strobes", 32'({bus_err, dev_we}), 32'h0);
      end
    end
  end

  task automatic stir();
    if (rand_irq) begin
      dev_irq = dev_irq ^ (NDEV'($urandom) & NDEV'($urandom));
      int_ack = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; stir();
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int lat, dev;
    e.rd = !we; e.err = 0; e.rdata = '0; e.we = '0; e.a = addr[3:2]; e.wd = wd;
    if (addr[1:0] != 2'b00) e.err = 1;
    else if (addr >= DEV_BASE && addr < DEV_BASE + 32'(16 * NDEV)) begin
      dev     = int'((addr - DEV_BASE) / 16);
      e.rdata = dev_rdata[32*dev +: 32];
      e.we    = NDEV'(1 << dev);
    end
    else if (addr == MASK_A) e.rdata = 32'(m_mask);
    else if (addr == PEND_A) e.rdata = 32'(m_pend);
    else if (addr == ID_A)   e.rdata = 32'(lowest(m_hw()));
    else e.err = 1;
    q.push_back(e);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = 0;
    forever begin
      @(negedge clk);
      if (cpu_ready) break;
      lat++;
      if (lat > 4) begin
        n_tests++; n_fail++;
        $display("FAIL ready_timeout: got no ready after %0d cycles expected at most 1", lat);
        break;
      end
      @(posedge clk); #1; stir();
    end
    chk("latency", 32'(lat), (we || e.err) ? 32'd0 : 32'd1);
    @(posedge clk); #1; cpu_req = 0; stir();
    if (e.err) begin
      @(negedge clk);
      chk("err_rdata0", cpu_rdata, 32'h0);
      @(posedge clk); #1; stir();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cpu_ready), 0);  chk("rst_err", 32'(bus_err), 0);
    chk("rst_we", 32'(dev_we), 0);        chk("rst_rdata", cpu_rdata, 0);
    chk("rst_hwint", 32'(hwint), 0);      chk("rst_id", 32'(int_id), 7);
    rst = 1;
    tick();

    dev_rdata = {32'h2222, 32'h1111};
    access(1, 32'h7F14, 32'h20);
    access(0, 32'h7F08, 32'h0);

`ifndef BRIDGE_LEVEL_IRQ_EN
    access(1, MASK_A, 32'h3);
    dev_irq = 2'b10; tick();
    chk("irq1_hwint", 32'(hwint), 32'h2); chk("irq1_id", 32'(int_id), 1);
    int_ack = 1; tick(); int_ack = 0;
    chk("ack_hwint", 32'(hwint), 0); chk("ack_id", 32'(int_id), 7);
    access(0, PEND_A, 0);

    access(1, MASK_A, 32'h1);
    dev_irq = 2'b00; tick();
    dev_irq = 2'b11; tick();
    chk("prio_hwint", 32'(hwint), 32'h1); chk("prio_id", 32'(int_id), 0);
    access(0, PEND_A, 0);
    access(1, PEND_A, 32'h1);
    chk("w1c_hwint", 32'(hwint), 0); chk("w1c_id", 32'(int_id), 7);
    access(0, PEND_A, 0);

    dev_irq = 2'b00; tick();
    dev_irq = 2'b01; tick();
    chk("pre_race_id", 32'(int_id), 0);
    dev_irq = 2'b00; tick();
    dev_irq = 2'b01; int_ack = 1; tick(); int_ack = 0;
    chk("race_set_wins", 32'(hwint), 32'h1);
    int_ack = 1; tick(); int_ack = 0;
    chk("race_then_ack", 32'(hwint), 0);
`endif

    access(0, 32'h7FC0, 0);
    access(0, 32'h7F20, 0);
    access(1, 32'h7F06, 32'h5);
    access(1, ID_A, 32'h1);

    rand_irq = 1;
    for (int n = 0; n < 300; n++) begin
      dev_rdata = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: access(1, DEV_BASE + 32'(16 * $urandom_range(0, NDEV-1)) + 32'(4 * $urandom_range(0, 3)), $urandom);
        1: access(0, DEV_BASE + 32'(16 * $urandom_range(0, NDEV-1)) + 32'(4 * $urandom_range(0, 3)), 0);
        2: access(1, MASK_A, $urandom);
        3: access(1, PEND_A, $urandom);
        4: access(0, MASK_A + 32'(4 * $urandom_range(0, 3)), 0);
        default: access($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? $urandom : 32'h7F80 + 32'($urandom_range(1, 3)), $urandom);
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_irq = 0; int_ack = 0;

    access(1, MASK_A, 32'h3);
    dev_irq = 2'b00; tick();
    dev_irq = 2'b11; tick();
    dev_rdata = {32'h2222, 32'hA5A5_0001};
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h7F0C; cpu_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("rdwait_ready", 32'(cpu_ready), 1);
    rst = 0; #1;
    chk("mid_rst_ready", 32'(cpu_ready), 0); chk("mid_rst_rdata", cpu_rdata, 0);
    chk("mid_rst_err", 32'(bus_err), 0);     chk("mid_rst_we", 32'(dev_we), 0);
    chk("mid_rst_daddr", 32'(dev_addr), 0);  chk("mid_rst_wdata", dev_wdata, 0);
    chk("mid_rst_hwint", 32'(hwint), 0);     chk("mid_rst_id", 32'(int_id), 7);
    cpu_req = 0;
    q.delete();
    @(posedge clk); #1; rst = 1;
    repeat (3) tick();
    access(0, PEND_A, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dev_irq_bridge.md
Name: dev_irq_bridge

Overview:
- Sits between the CPU data-memory port and up to six timer-style peripherals, each with a 4-word register window.
- Decodes CPU addresses and steers one shared peripheral bus (2-bit word address, write data, per-device write enable).
- Returns read data through a one-wait-state handshake.
- Captures peripheral IRQs into maskable pending latches and presents them to CP0 as HWInt[5:0], with an acknowledge path.

Parameters:
- NDEV, 2, number of attached peripherals (1..6).
- DEV_BASE, 32'h0000_7F00, base of the device windows; device i occupies DEV_BASE+16*i .. +15.
- CTL_BASE, 32'h0000_7F80, base of the bridge's own registers.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request, held until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address, word aligned
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_ready=1 on a read
- cpu_ready  out  1  access complete this cycle
- bus_err  out  1  one-cycle pulse: access to an unmapped or misaligned address
- dev_addr  out  2  shared word index to peripherals
- dev_wdata  out  32  shared write data
- dev_we  out  NDEV  one-hot write enable
- dev_rdata  in  32*NDEV  flattened read data, device i at [32i+31:32i]
- dev_irq  in  NDEV  peripheral interrupt levels
- int_ack  in  1  CP0 took an interrupt (one-cycle pulse)
- hwint  out  6  pending & mask, zero-extended above NDEV
- int_id  out  3  index of the lowest-numbered active hwint bit; 7 if none

Behaviour:
- Reset (rst=0, async): FSM=IDLE; mask=0; pending=0; irq_q=0; cpu_rdata=0; cpu_ready=0; bus_err=0; dev_we=0; dev_addr=0; dev_wdata=0; hwint=0; int_id=7.
- Address decode:
  - device window: cpu_addr[31:4]==(DEV_BASE>>4)+i with i<NDEV; dev_addr=cpu_addr[3:2].
  - CTL window: 0x7F80 MASK (rw, [NDEV-1:0]); 0x7F84 PENDING (read; write-1-to-clear); 0x7F88 ID (read-only = int_id).
  - Anything else, or cpu_addr[1:0]!=0, is unmapped.
- dev_addr and dev_wdata are combinational from cpu_addr/cpu_wdata.
- FSM has two states, IDLE and RD_WAIT:
  - IDLE, req & we, mapped: dev_we[i]=1 combinationally for this cycle only. Bridge registers update at this clock edge. cpu_ready=1 the same cycle. Stay IDLE.
  - IDLE, req & !we, mapped: register the selected dev_rdata slice or CTL register into cpu_rdata. Go to RD_WAIT.
  - RD_WAIT: cpu_ready=1, cpu_rdata holds the value. Return to IDLE. Read latency is 1 wait state, and dev_we=0 in this state.
  - Unmapped access (read or write) in IDLE: no dev_we; cpu_rdata<=0; bus_err=1 and cpu_ready=1 in the same cycle. Stay IDLE.
  - cpu_req low in IDLE: no action.
- Each access is handled once. The CPU drops or changes cpu_req after cpu_ready; a req still high in the cycle after cpu_ready starts a new access.
- IRQ capture:
  - irq_q<=dev_irq every cycle.
  - rise[i]=dev_irq[i]&~irq_q[i] sets pending[i].
- Pending clear sources:
  - int_ack clears pending[int_id] when int_id!=7.
  - a PENDING write clears every bit where wdata=1.
- Same-cycle set and clear on one bit: set wins.
- Masked bits still latch into pending but do not appear on hwint.
- hwint and int_id are combinational from the pending and mask registers; no extra latency beyond the register update.
- Reset mid-access: cpu_ready drops immediately and the access is lost.

Optional Feature:
- Macro BRIDGE_LEVEL_IRQ_EN.
- Defined: pending[i] ignores edge capture and directly mirrors dev_irq[i] each cycle (registered, 1-cycle delay). int_ack and PENDING writes have no effect; the peripheral must drop its IRQ.
- Undefined: edge-latched, sticky pending as described above.

Decomposition:
- Shared package holds:
  - address constants DEV_BASE, CTL_BASE and the MASK/PENDING/ID offsets
  - FSM state encoding (IDLE=1'b0, RD_WAIT=1'b1)
  - the INT_NONE=3'd7 constant
- One natural sub-module, irq_pend_ctrl: edge detect, pending latch, mask AND, priority encoder. The bridge keeps decode and FSM.

Test Plan:
- Write dev1 preset: req, we, addr 0x7F14, wdata 0x20 -> same cycle dev_we=2'b10, dev_addr=1, dev_wdata=0x20, cpu_ready=1.
- Read dev0 count: dev_rdata[31:0]=0x1111, read 0x7F08 -> cycle0 ready=0; cycle1 ready=1, rdata=0x1111, FSM returns IDLE.
- Mask and IRQ: write MASK=0x3, raise dev_irq[1] -> next cycle pending=0x2, hwint=6'b000010, int_id=1. Pulse int_ack -> pending=0, int_id=7.
- Priority plus masked latch: MASK=0x1, raise dev_irq=2'b11 -> pending=0x3, hwint=0x1, int_id=0. Write PENDING 0x1 -> pending=0x2, hwint=0, int_id=7.
- Set-vs-clear race: a rising edge on dev_irq[0] in the same cycle as int_ack targeting bit 0 -> pending[0] stays 1.
- Unmapped read of 0x7FC0 -> cpu_ready=1 and bus_err=1 in the same cycle, rdata=0, dev_we=0. Assert rst during RD_WAIT -> all outputs zero, int_id=7.
